// File: rtl/cmd_queue_decoder.sv
// Draw-command decoder with a DEPTH-entry FIFO and a registered valid/ready output stage.
// Optional build macro CMDQ_CLIP_EN clamps coordinates to MAX_X/MAX_Y and adds a 'clipped' output.
module cmd_queue_decoder #(
    parameter int unsigned COORD_W = 9,
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_X   = 319,
    parameter int unsigned MAX_Y   = 239
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [4+4*COORD_W+COLOR_W-1:0]     cmd_data,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [1:0]                         op,
    output logic [COORD_W-1:0]                 x1,
    output logic [COORD_W-1:0]                 y1,
    output logic [COORD_W-1:0]                 x2,
    output logic [COORD_W-1:0]                 y2,
    output logic [COLOR_W-1:0]                 color,
    output logic                               cmd_done,
    output logic                               err_invalid,
`ifdef CMDQ_CLIP_EN
    output logic [$clog2(DEPTH+1)-1:0]         level,
    output logic                               clipped
`else
    output logic [$clog2(DEPTH+1)-1:0]         level
`endif
);

    localparam int unsigned CMD_W     = 4 + 4*COORD_W + COLOR_W;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned LVL_W     = $clog2(DEPTH+1);
    localparam int unsigned RSV_LSB   = COLOR_W;
    localparam int unsigned Y2_LSB    = COLOR_W + 2;
    localparam int unsigned X2_LSB    = Y2_LSB + COORD_W;
    localparam int unsigned Y1_LSB    = X2_LSB + COORD_W;
    localparam int unsigned X1_LSB    = Y1_LSB + COORD_W;
    localparam int unsigned OP_LSB    = X1_LSB + COORD_W;

    localparam logic [1:0] OP_LINE  = 2'b00;
    localparam logic [1:0] OP_RECT  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_BAD   = 2'b11;

    typedef struct packed {
        logic [1:0]         op;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
        logic [COLOR_W-1:0] color;
`ifdef CMDQ_CLIP_EN
        logic               clip;
`endif
    } entry_t;

    entry_t               dec_c;
    entry_t               out_q;
    entry_t               mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_nxt_c;
    logic                 accept_c;
    logic                 push_c;
    logic                 bad_c;
    logic                 pop_c;
    logic                 unused_rsv;

    // Reserved command bits carry no meaning
    assign unused_rsv = ^cmd_data[RSV_LSB +: 2];

`ifndef CMDQ_CLIP_EN
    logic unused_max;
    assign unused_max = (MAX_X == 0) ^ (MAX_Y == 0);
`endif

    // Field extraction and normalisation applied before the entry enters the FIFO
    always_comb begin
        dec_c       = '0;
        dec_c.op    = cmd_data[OP_LSB +: 2];
        dec_c.x1    = cmd_data[X1_LSB +: COORD_W];
        dec_c.y1    = cmd_data[Y1_LSB +: COORD_W];
        dec_c.x2    = cmd_data[X2_LSB +: COORD_W];
        dec_c.y2    = cmd_data[Y2_LSB +: COORD_W];
        dec_c.color = cmd_data[COLOR_W-1:0];
        case (dec_c.op)
            OP_RECT: begin
                if (cmd_data[X1_LSB +: COORD_W] > cmd_data[X2_LSB +: COORD_W]) begin
                    dec_c.x1 = cmd_data[X2_LSB +: COORD_W];
                    dec_c.x2 = cmd_data[X1_LSB +: COORD_W];
                end
                if (cmd_data[Y1_LSB +: COORD_W] > cmd_data[Y2_LSB +: COORD_W]) begin
                    dec_c.y1 = cmd_data[Y2_LSB +: COORD_W];
                    dec_c.y2 = cmd_data[Y1_LSB +: COORD_W];
                end
            end
            OP_CLEAR: begin
                dec_c.x1 = '0;
                dec_c.y1 = '0;
                dec_c.x2 = '1;
                dec_c.y2 = '1;
            end
            default: ;
        endcase
`ifdef CMDQ_CLIP_EN
        // Clamp runs after normalisation so CLEAR lands on the screen extent
        dec_c.clip = 1'b0;
        if (dec_c.x1 > COORD_W'(MAX_X)) begin
            dec_c.x1   = COORD_W'(MAX_X);
            dec_c.clip = 1'b1;
        end
        if (dec_c.x2 > COORD_W'(MAX_X)) begin
            dec_c.x2   = COORD_W'(MAX_X);
            dec_c.clip = 1'b1;
        end
        if (dec_c.y1 > COORD_W'(MAX_Y)) begin
            dec_c.y1   = COORD_W'(MAX_Y);
            dec_c.clip = 1'b1;
        end
        if (dec_c.y2 > COORD_W'(MAX_Y)) begin
            dec_c.y2   = COORD_W'(MAX_Y);
            dec_c.clip = 1'b1;
        end
`endif
    end

    assign accept_c    = cmd_valid && cmd_ready;
    assign push_c      = accept_c && (dec_c.op != OP_BAD);
    assign bad_c       = accept_c && (dec_c.op == OP_BAD);
    assign pop_c       = (level != '0) && (!out_valid || out_ready);
    assign level_nxt_c = level + LVL_W'(push_c) - LVL_W'(pop_c);

    // FIFO storage needs no reset; occupancy is tracked by level
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= dec_c;
        end
    end

    // Pointers, occupancy, ready and status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            cmd_ready   <= 1'b0;
            cmd_done    <= 1'b0;
            err_invalid <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level       <= level_nxt_c;
            cmd_ready   <= (level_nxt_c != LVL_W'(DEPTH));
            cmd_done    <= out_valid && out_ready;
            err_invalid <= bad_c;
        end
    end

    // Output register: refills from the FIFO head whenever it is free or being drained
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (pop_c) begin
            out_q     <= mem[rd_ptr];
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign op    = out_q.op;
    assign x1    = out_q.x1;
    assign y1    = out_q.y1;
    assign x2    = out_q.x2;
    assign y2    = out_q.y2;
    assign color = out_q.color;
`ifdef CMDQ_CLIP_EN
    assign clipped = out_q.clip;
`endif

endmodule

// File: tb/tb_cmd_queue_decoder.sv
// Directed bench for cmd_queue_decoder: reset, decode, drop, back-pressure, clear and mid-run reset.
module tb_cmd_queue_decoder;

    localparam int unsigned COORD_W = 9;
    localparam int unsigned COLOR_W = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CMD_W   = 4 + 4*COORD_W + COLOR_W;
    localparam int unsigned LVL_W   = $clog2(DEPTH+1);

    logic                 clk;
    logic                 reset;
    logic [CMD_W-1:0]     cmd_data;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           op;
    logic [COORD_W-1:0]   x1, y1, x2, y2;
    logic [COLOR_W-1:0]   color;
    logic                 cmd_done;
    logic                 err_invalid;
    logic [LVL_W-1:0]     level;
`ifdef CMDQ_CLIP_EN
    logic                 clipped;
`endif

    int chk_n;
    int pass_n;

    cmd_queue_decoder #(
        .COORD_W(COORD_W),
        .COLOR_W(COLOR_W),
        .DEPTH  (DEPTH),
        .MAX_X  (319),
        .MAX_Y  (239)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op         (op),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .color      (color),
        .cmd_done   (cmd_done),
        .err_invalid(err_invalid),
`ifdef CMDQ_CLIP_EN
        .level      (level),
        .clipped    (clipped)
`else
        .level      (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CMD_W-1:0] mk(input logic [1:0] o, input int a, input int b,
                                            input int c, input int d, input int col);
        return {o, COORD_W'(a), COORD_W'(b), COORD_W'(c), COORD_W'(d), 2'b11, COLOR_W'(col)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; cmd_valid = 1'b0; out_ready = 1'b0; cmd_data = '0;
        repeat (3) tick();
        chk_n++;
        if ({cmd_ready, out_valid, cmd_done, err_invalid} !== 4'b0000)
            $display("FAIL reset_flags: got %b exp 0000", {cmd_ready, out_valid, cmd_done, err_invalid});
        else pass_n++;
        chk_n++;
        if (level !== '0) $display("FAIL reset_level: got %0d exp 0", level);
        else pass_n++;
        chk_n++;
        if ({op, x1, y1, x2, y2, color} !== '0)
            $display("FAIL reset_fields: got %h exp 0", {op, x1, y1, x2, y2, color});
        else pass_n++;
        reset = 1'b1;
        tick();
        chk_n++;
        if (cmd_ready !== 1'b1) $display("FAIL ready_after_reset: got %b exp 1", cmd_ready);
        else pass_n++;
    endtask

    task automatic test_line;
        out_ready = 1'b1;
        cmd_data  = mk(2'b00, 0, 0, 5, 5, 8'hFF);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk_n++;
        if ({out_valid, level} !== {1'b0, LVL_W'(1)})
            $display("FAIL line_edge1: got valid=%b level=%0d exp valid=0 level=1", out_valid, level);
        else pass_n++;
        tick();
        chk_n++;
        if ({out_valid, op, x1, y1, x2, y2, color} !==
            {1'b1, 2'b00, COORD_W'(0), COORD_W'(0), COORD_W'(5), COORD_W'(5), 8'hFF})
            $display("FAIL line_fields: got v=%b op=%b %0d,%0d,%0d,%0d c=%h", out_valid, op, x1, y1, x2, y2, color);
        else pass_n++;
        chk_n++;
        if ({cmd_done, level} !== {1'b0, LVL_W'(0)})
            $display("FAIL line_done_early: got done=%b level=%0d exp 0,0", cmd_done, level);
        else pass_n++;
        tick();
        chk_n++;
        if ({out_valid, cmd_done} !== 2'b01)
            $display("FAIL line_handshake: got valid=%b done=%b exp 0,1", out_valid, cmd_done);
        else pass_n++;
        tick();
        chk_n++;
        if (cmd_done !== 1'b0) $display("FAIL line_done_once: got %b exp 0", cmd_done);
        else pass_n++;
    endtask

    task automatic test_rect;
        out_ready = 1'b1;
        cmd_data  = mk(2'b01, 15, 12, 10, 10, 8'hAA);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk_n++;
        if ({out_valid, op, x1, y1, x2, y2, color} !==
            {1'b1, 2'b01, COORD_W'(10), COORD_W'(10), COORD_W'(15), COORD_W'(12), 8'hAA})
            $display("FAIL rect_norm: got v=%b op=%b %0d,%0d,%0d,%0d c=%h exp 1 01 10,10,15,12 aa",
                     out_valid, op, x1, y1, x2, y2, color);
        else pass_n++;
        repeat (2) tick();
    endtask

    task automatic test_invalid;
        out_ready = 1'b1;
        cmd_data  = mk(2'b11, 1, 2, 3, 4, 8'hBB);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk_n++;
        if ({err_invalid, out_valid, level} !== {1'b1, 1'b0, LVL_W'(0)})
            $display("FAIL invalid_pulse: got err=%b valid=%b level=%0d exp 1,0,0", err_invalid, out_valid, level);
        else pass_n++;
        tick();
        chk_n++;
        if ({err_invalid, out_valid, cmd_done, level} !== {3'b000, LVL_W'(0)})
            $display("FAIL invalid_after: got err=%b valid=%b done=%b level=%0d exp 0,0,0,0",
                     err_invalid, out_valid, cmd_done, level);
        else pass_n++;
    endtask

    task automatic test_back_to_back;
        int  n;
        int  e;
        logic acc;
        logic hs;
        out_ready = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 5; cyc++) begin
            cmd_data  = mk(2'b00, n, n + 1, n + 2, n + 3, 16 + n);
            cmd_valid = 1'b1;
            acc = cmd_ready;
            tick();
            if (acc) n++;
        end
        cmd_data  = mk(2'b00, 5, 6, 7, 8, 21);
        cmd_valid = 1'b1;
        repeat (2) tick();
        chk_n++;
        if (n !== 5) $display("FAIL b2b_fill: accepted %0d exp 5", n);
        else pass_n++;
        chk_n++;
        if ({level, cmd_ready, out_valid} !== {LVL_W'(4), 1'b0, 1'b1})
            $display("FAIL b2b_full: got level=%0d ready=%b valid=%b exp 4,0,1", level, cmd_ready, out_valid);
        else pass_n++;
        chk_n++;
        if ({x1, color} !== {COORD_W'(0), 8'h10})
            $display("FAIL b2b_held: got x1=%0d c=%h exp 0 10", x1, color);
        else pass_n++;
        out_ready = 1'b1;
        e = 0;
        for (int cyc = 0; cyc < 20 && e < 6; cyc++) begin
            hs = out_valid;
            chk_n++;
            if (out_valid !== 1'b1) $display("FAIL b2b_gap: got valid=%b exp 1 at item %0d", out_valid, e);
            else pass_n++;
            if (hs) begin
                chk_n++;
                if ({x1, color} !== {COORD_W'(e), COLOR_W'(16 + e)})
                    $display("FAIL b2b_order: got x1=%0d c=%h exp %0d %h", x1, color, e, COLOR_W'(16 + e));
                else pass_n++;
                e++;
            end
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) cmd_valid = 1'b0;
            chk_n++;
            if (cmd_done !== hs) $display("FAIL b2b_done: got %b exp %b", cmd_done, hs);
            else pass_n++;
        end
        chk_n++;
        if ({e, out_valid, level, cmd_valid} !== {32'd6, 1'b0, LVL_W'(0), 1'b0})
            $display("FAIL b2b_drain: got items=%0d valid=%b level=%0d pending=%b exp 6,0,0,0",
                     e, out_valid, level, cmd_valid);
        else pass_n++;
        tick();
    endtask

    task automatic test_clear;
        out_ready = 1'b1;
        cmd_data  = mk(2'b10, 7, 8, 9, 10, 8'h00);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk_n++;
`ifdef CMDQ_CLIP_EN
        if ({out_valid, op, x1, y1, x2, y2, color, clipped} !==
            {1'b1, 2'b10, COORD_W'(0), COORD_W'(0), COORD_W'(319), COORD_W'(239), 8'h00, 1'b1})
            $display("FAIL clear_fields: got v=%b op=%b %0d,%0d,%0d,%0d c=%h clip=%b exp 1 10 0,0,319,239 00 1",
                     out_valid, op, x1, y1, x2, y2, color, clipped);
`else
        if ({out_valid, op, x1, y1, x2, y2, color} !==
            {1'b1, 2'b10, COORD_W'(0), COORD_W'(0), COORD_W'(511), COORD_W'(511), 8'h00})
            $display("FAIL clear_fields: got v=%b op=%b %0d,%0d,%0d,%0d c=%h exp 1 10 0,0,511,511 00",
                     out_valid, op, x1, y1, x2, y2, color);
`endif
        else pass_n++;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid;
        int  n;
        logic acc;
        out_ready = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            cmd_data  = mk(2'b00, n, n, n, n, 32 + n);
            cmd_valid = 1'b1;
            acc = cmd_ready;
            tick();
            if (acc) n++;
        end
        cmd_valid = 1'b0;
        chk_n++;
        if ({level, out_valid} !== {LVL_W'(3), 1'b1})
            $display("FAIL mid_preload: got level=%0d valid=%b exp 3,1", level, out_valid);
        else pass_n++;
        reset = 1'b0;
        #2;
        chk_n++;
        if ({level, out_valid, cmd_ready, x1, color} !== '0)
            $display("FAIL mid_async_clear: got level=%0d valid=%b ready=%b x1=%0d c=%h exp all 0",
                     level, out_valid, cmd_ready, x1, color);
        else pass_n++;
        out_ready = 1'b1;
        repeat (2) tick();
        chk_n++;
        if ({cmd_done, out_valid} !== 2'b00)
            $display("FAIL mid_no_done: got done=%b valid=%b exp 0,0", cmd_done, out_valid);
        else pass_n++;
        reset = 1'b1;
        tick();
        chk_n++;
        if ({level, out_valid, cmd_ready} !== {LVL_W'(0), 1'b0, 1'b1})
            $display("FAIL mid_release: got level=%0d valid=%b ready=%b exp 0,0,1", level, out_valid, cmd_ready);
        else pass_n++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        chk_n  = 0;
        pass_n = 0;
        test_reset();
        test_line();
        test_rect();
        test_invalid();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule

// File: doc/cmd_queue_decoder.md
Name: cmd_queue_decoder

Overview:
Parametrised successor to the single-command decoder. Accepts packed draw commands on a valid/ready input, drops invalid opcodes, and queues valid ones in a DEPTH-entry FIFO. Presents decoded, normalised fields to the rasteriser on a registered valid/ready output. Sits between the host command port and the line/rect rasteriser, and absorbs back-pressure while the rasteriser is busy.

Parameters:
COORD_W, 9, coordinate field width in bits
COLOR_W, 8, colour field width in bits
DEPTH, 4, FIFO entries; power of two, minimum 2
MAX_X, 319, largest legal x; used only with CMDQ_CLIP_EN
MAX_Y, 239, largest legal y; used only with CMDQ_CLIP_EN

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_data  in  CMD_W  packed command; CMD_W = 4 + 4*COORD_W + COLOR_W (48 at defaults)
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
out_valid  out  1  decoded command held on outputs
out_ready  in  1  rasteriser accepts the held command
op  out  2  00 LINE, 01 RECT, 10 CLEAR
x1, y1, x2, y2  out  COORD_W each  decoded coordinates
color  out  COLOR_W  decoded colour
cmd_done  out  1  one-cycle pulse on each output handshake
err_invalid  out  1  one-cycle pulse when an opcode-11 command is dropped
level  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register

Behaviour:
- Packing, MSB first: opcode[1:0], x1, y1, x2, y2, 2 reserved bits (ignored), color.
- Reset asserted (reset=0): FIFO empties, pointers clear, level=0, cmd_ready=0 while reset is held, out_valid=0, cmd_done=0, err_invalid=0, and op/x1/y1/x2/y2/color=0.
- cmd_ready = !full. It is registered and goes high on the first edge after reset deasserts.
- Accept: at an edge where cmd_valid && cmd_ready.
  - Opcode 11: nothing is written; err_invalid pulses in the next cycle.
  - Any other opcode: the decoded entry is written to the FIFO.
- Decode at write time:
  - LINE: fields pass through unchanged.
  - RECT: normalised so x1<=x2 and y1<=y2 (swap per axis).
  - CLEAR: coordinates forced to 0,0 to 2^COORD_W-1, 2^COORD_W-1; colour passes through.
- Output register loads the FIFO head at an edge where the FIFO is non-empty and (!out_valid || out_ready).
- Latency: a command accepted at edge N into an empty FIFO with a free output register shows out_valid=1 after edge N+1.
- Outputs stay stable while out_valid && !out_ready.
- out_valid clears after a handshake edge if the FIFO is empty; otherwise the next entry loads in the same edge, giving back-to-back throughput of 1/cycle.
- cmd_done is high for the cycle after each out_valid && out_ready edge.
- Full: no write even if a pop occurs in the same cycle. cmd_ready rises the cycle after the pop.
- Simultaneous push and pop when not full: level is unchanged.
- Pointers wrap modulo DEPTH.
- Reset mid-operation discards all queued and held commands with no cmd_done pulse.

Optional Feature:
CMDQ_CLIP_EN
- Defined: at write time each x is clamped to MAX_X and each y to MAX_Y, after RECT normalisation. CLEAR coordinates become 0,0 to MAX_X,MAX_Y. An extra output port `clipped` (1 bit) is registered alongside op and is high for any entry in which a clamp occurred.
- Undefined: no clamping, no `clipped` port, and MAX_X/MAX_Y are unused.

Test Plan:
1. Reset, then send LINE (0,0)-(5,5) colour 0xFF with out_ready=1 -> out_valid after the second edge; op=00, fields exact; cmd_done pulses once.
2. Send RECT (15,12)-(10,10) colour 0xAA -> outputs x1=10, y1=10, x2=15, y2=12, op=01.
3. Send opcode 11 with colour 0xBB -> err_invalid pulses once, level stays 0, no out_valid, no cmd_done.
4. Hold out_ready=0 and push 6 commands at DEPTH=4 -> 1 is held in the output register, level=4, cmd_ready=0. The 6th waits. Release out_ready -> all 6 emerge in order with one cmd_done each and no gap.
5. Send CLEAR colour 0x00 -> op=10, coordinates 0,0 to 511,511. With CMDQ_CLIP_EN: 319,239, and clipped=1.
6. Pull reset low with 3 entries queued and out_valid=1 -> everything clears asynchronously. After release, level=0, out_valid=0, cmd_ready=1.
